freq_synth_gen: RTL and testbench
=================================

# freq_synth_gen

Programmable multi-channel square-wave generator driven from the reference clock. Each channel uses a phase accumulator (NCO) to produce a known, run-time-selectable rate: a test-stimulus and self-check source for the clock-rate measurement path. Software stages per-channel settings into shadow registers, then applies them to all channels together with a single commit. Commit can also phase-align all channels.

## Interface
- NUM_SIGNALS, 4: number of generator channels (1..16).
- ACC_W, 32: phase accumulator width; also the increment width.
- ref_clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_wr  in  1  one-cycle write strobe into the shadow registers of channel cfg_addr.
- cfg_addr  in  4  target channel; writes with cfg_addr >= NUM_SIGNALS are ignored.
- cfg_inc  in  ACC_W  phase increment for shadow.
- cfg_en  in  1  channel enable for shadow.
- cfg_commit  in  1  copies all shadows to the active registers.
- cfg_sync  in  1  sampled only with cfg_commit. When 1, clears all accumulators and outputs at commit.
- commit_ack  out  1  one-cycle pulse, the cycle after a commit is accepted.
- signal  out  NUM_SIGNALS  registered square-wave outputs.
- rise_stb  out  NUM_SIGNALS  one-cycle pulse on the cycle signal[i] goes 0->1.

## Operation
- Per channel state:
  - shadow_inc/shadow_en
  - act_inc/act_en
  - acc[ACC_W-1:0]
  - signal[i]
- **Shadow write.** cfg_wr with a valid address loads shadow_inc/shadow_en on the next edge. There is no effect on the output until commit.
- **Commit.** cfg_commit loads act_inc/act_en from the shadows of every channel simultaneously.
  - A cfg_wr in the same cycle is bypassed into the commit, so the committed value for that channel is the new write.
- **Accumulate.** Each cycle, for enabled channels:
  - sum = acc + act_inc, computed ACC_W+1 bits wide.
  - acc <= sum[ACC_W-1:0]
  - carry = sum[ACC_W]
  - signal <= signal ^ carry
  - rise_stb <= carry & ~signal
- Output frequency is f_ref * act_inc / 2^(ACC_W+1). The maximum is f_ref/2 (toggle every cycle). The accumulator wraps modulo 2^ACC_W, and at most one carry occurs per cycle.
- **act_inc = 0 with act_en = 1.** signal holds its current level and rise_stb stays 0.
- **Disable.** When act_en = 0, acc, signal and rise_stb are held at 0. Re-enabling starts from phase 0, so the first rising edge comes after ceil(2^ACC_W / inc) cycles.
- **Rate change while enabled.** A commit that changes act_inc keeps acc and signal (phase-continuous, no glitch, no short half-period beyond one accumulator step).
- **cfg_sync = 1 with cfg_commit.** All acc and signal are forced to 0 on the commit edge, regardless of the new settings. Channels with equal increments are then edge-aligned.
- **Reset.** Asserting rst_n low at any time, including mid-period, clears everything:
  - shadows, actives, acc, signal, rise_stb and commit_ack all go to 0 immediately.
  - All channels are disabled after release.

## Timing
- Write at cycle N: the shadow is valid at N+1.
- Commit at cycle M:
  - act_* are valid at M+1.
  - The first accumulate using the new increment updates acc at edge M+2.
  - commit_ack is high during M+1.
- Enable path: with commit at M (sync or re-enable), the earliest carry is at the edge ending cycle M+k, where k = ceil(2^ACC_W / inc). signal rises and rise_stb pulses in that following cycle.
- Outputs are directly registered, with no combinational path from inputs to outputs.
- Back-to-back commits on consecutive cycles are accepted. Each one produces its own commit_ack pulse.
- The release of rst_n is synchronized externally. The block needs no internal reset synchronizer.

## Test plan
- **Basic rate.** ACC_W=32. Write ch0 inc=0x4000_0000, en=1, then commit. Required response:
  - signal[0] toggles every 4 cycles (period 8).
  - rise_stb[0] pulses every 8 cycles.
  - The first rise is 4 cycles after act_* are valid.
- **Shadow isolation.** With ch0 running, write inc=0x8000_0000 without a commit. Required response:
  - The period stays 8 for 100 cycles.
  - After a commit, the period becomes 4, and the transition is phase-continuous with no half-period shorter than 2 cycles.
- **Sync alignment.**
  - Set ch0 inc=0x1000_0000 and ch1 inc=0x1000_0000, with ch1 written 5 cycles later and committed separately.
  - Then commit with cfg_sync=1.
  - Required response: signal[0] == signal[1] on every cycle afterwards, with rises every 32 cycles.
- **Max rate / edge values.**
  - inc=0xFFFF_FFFF toggles on all but one cycle per 2^32.
  - Over 1000 cycles, the toggle count is 1000 (±1).
  - inc=0 with en=1 holds the current level.
  - A write to cfg_addr=NUM_SIGNALS changes nothing.
- **Disable / same-cycle bypass.**
  - Assert cfg_wr (ch2, en=0) in the same cycle as cfg_commit. Required response: signal[2]=0 at M+1 and commit_ack is high at M+1.
  - Re-enable. Required response: the first rise occurs after the full k cycles.
- **Reset mid-operation.** Drop rst_n during a high half-period of all channels. Required response:
  - All outputs go to 0 immediately.
  - After release, signal stays 0 with no rise_stb until a new write and commit.

Source files
------------

// File: rtl/freq_synth_gen.sv
// Multi-channel NCO square-wave generator with shadowed configuration and a
// global commit that can optionally phase-align every channel.
module freq_synth_gen #(
    parameter int unsigned NUM_SIGNALS = 4,
    parameter int unsigned ACC_W       = 32
) (
    input  logic                   ref_clk,
    input  logic                   rst_n,
    input  logic                   cfg_wr,
    input  logic [3:0]             cfg_addr,
    input  logic [ACC_W-1:0]       cfg_inc,
    input  logic                   cfg_en,
    input  logic                   cfg_commit,
    input  logic                   cfg_sync,
    output logic                   commit_ack,
    output logic [NUM_SIGNALS-1:0] signal,
    output logic [NUM_SIGNALS-1:0] rise_stb
);

    logic [NUM_SIGNALS-1:0][ACC_W-1:0] shadow_inc_q, shadow_inc_d;
    logic [NUM_SIGNALS-1:0][ACC_W-1:0] act_inc_q, act_inc_d;
    logic [NUM_SIGNALS-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [NUM_SIGNALS-1:0]            shadow_en_q, shadow_en_d;
    logic [NUM_SIGNALS-1:0]            act_en_q, act_en_d;
    logic [NUM_SIGNALS-1:0]            signal_q, signal_d;
    logic [NUM_SIGNALS-1:0]            rise_q, rise_d;
    logic                              commit_ack_q;
    logic [ACC_W:0]                    sum;

    // Out-of-range addresses never match any channel, so they are dropped here.
    always_comb begin
        shadow_inc_d = shadow_inc_q;
        shadow_en_d  = shadow_en_q;
        for (int unsigned i = 0; i < NUM_SIGNALS; i++) begin
            if (cfg_wr && (cfg_addr == 4'(i))) begin
                shadow_inc_d[i] = cfg_inc;
                shadow_en_d[i]  = cfg_en;
            end
        end
        // Commit takes the post-write shadows, so a same-cycle write is bypassed in.
        act_inc_d = cfg_commit ? shadow_inc_d : act_inc_q;
        act_en_d  = cfg_commit ? shadow_en_d  : act_en_q;
    end

    // A channel being disabled by this commit clears on the commit edge itself.
    always_comb begin
        acc_d    = acc_q;
        signal_d = signal_q;
        rise_d   = '0;
        sum      = '0;
        for (int unsigned i = 0; i < NUM_SIGNALS; i++) begin
            sum = {1'b0, acc_q[i]} + {1'b0, act_inc_q[i]};
            if (!act_en_q[i] || !act_en_d[i] || (cfg_commit && cfg_sync)) begin
                acc_d[i]    = '0;
                signal_d[i] = 1'b0;
                rise_d[i]   = 1'b0;
            end else begin
                acc_d[i]    = sum[ACC_W-1:0];
                signal_d[i] = signal_q[i] ^ sum[ACC_W];
                rise_d[i]   = sum[ACC_W] & ~signal_q[i];
            end
        end
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_inc_q <= '0;
            shadow_en_q  <= '0;
            act_inc_q    <= '0;
            act_en_q     <= '0;
            acc_q        <= '0;
            signal_q     <= '0;
            rise_q       <= '0;
            commit_ack_q <= 1'b0;
        end else begin
            shadow_inc_q <= shadow_inc_d;
            shadow_en_q  <= shadow_en_d;
            act_inc_q    <= act_inc_d;
            act_en_q     <= act_en_d;
            acc_q        <= acc_d;
            signal_q     <= signal_d;
            rise_q       <= rise_d;
            commit_ack_q <= cfg_commit;
        end
    end

    assign commit_ack = commit_ack_q;
    assign signal     = signal_q;
    assign rise_stb   = rise_q;

endmodule

// File: tb/tb_freq_synth_gen.sv
// Bench for freq_synth_gen: cycle-level scoreboard against a phase-arithmetic
// model, plus directed rate, alignment, bypass and reset checks.
module tb_freq_synth_gen;
    localparam int unsigned N     = 4;
    localparam int unsigned ACC_W = 32;
    localparam longint unsigned MOD = 64'd1 << ACC_W;

    logic             ref_clk;
    logic             rst_n;
    logic             cfg_wr;
    logic [3:0]       cfg_addr;
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_en;
    logic             cfg_commit;
    logic             cfg_sync;
    logic             commit_ack;
    logic [N-1:0]     signal;
    logic [N-1:0]     rise_stb;

    freq_synth_gen #(.NUM_SIGNALS(N), .ACC_W(ACC_W)) dut (
        .ref_clk    (ref_clk),
        .rst_n      (rst_n),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_inc    (cfg_inc),
        .cfg_en     (cfg_en),
        .cfg_commit (cfg_commit),
        .cfg_sync   (cfg_sync),
        .commit_ack (commit_ack),
        .signal     (signal),
        .rise_stb   (rise_stb)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(string name, int val, int lo, int hi);
        total++;
        if (val < lo || val > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    // Reference model: phase as a plain integer, carry when it passes 2^ACC_W.
    longint unsigned m_phase[N];
    longint unsigned m_sh_inc[N];
    longint unsigned m_act_inc[N];
    bit              m_sh_en[N];
    bit              m_act_en[N];
    bit              m_lvl[N];
    bit              m_rise[N];
    logic [8:0]      exp_q[$];

    initial begin
        int         a;
        logic [N-1:0] lv;
        logic [N-1:0] rs;
        for (int i = 0; i < N; i++) begin
            m_phase[i] = 0; m_sh_inc[i] = 0; m_act_inc[i] = 0;
            m_sh_en[i] = 0; m_act_en[i] = 0; m_lvl[i] = 0; m_rise[i] = 0;
        end
        forever begin
            @(posedge ref_clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    m_phase[i] = 0; m_sh_inc[i] = 0; m_act_inc[i] = 0;
                    m_sh_en[i] = 0; m_act_en[i] = 0; m_lvl[i] = 0; m_rise[i] = 0;
                end
                exp_q.delete();
            end else begin
                a = int'(cfg_addr);
                if (cfg_wr && a < N) begin
                    m_sh_inc[a] = longint'(cfg_inc);
                    m_sh_en[a]  = cfg_en;
                end
                for (int i = 0; i < N; i++) begin
                    if (cfg_commit && cfg_sync) begin
                        m_phase[i] = 0; m_lvl[i] = 0; m_rise[i] = 0;
                    end else if (!m_act_en[i] || (cfg_commit && !m_sh_en[i])) begin
                        m_phase[i] = 0; m_lvl[i] = 0; m_rise[i] = 0;
                    end else begin
                        m_phase[i] = m_phase[i] + m_act_inc[i];
                        m_rise[i]  = 0;
                        if (m_phase[i] >= MOD) begin
                            m_phase[i] = m_phase[i] - MOD;
                            m_rise[i]  = !m_lvl[i];
                            m_lvl[i]   = !m_lvl[i];
                        end
                    end
                end
                if (cfg_commit) begin
                    for (int i = 0; i < N; i++) begin
                        m_act_inc[i] = m_sh_inc[i];
                        m_act_en[i]  = m_sh_en[i];
                    end
                end
                for (int i = 0; i < N; i++) begin
                    lv[i] = m_lvl[i];
                    rs[i] = m_rise[i];
                end
                exp_q.push_back({cfg_commit, lv, rs});
            end
        end
    end

    // Monitor: compares every presented output cycle, and keeps edge counters.
    int           rise_cnt[N];
    int           tog_cnt[N];
    int           mis01;
    logic [N-1:0] prev_sig;

    initial begin
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            rise_cnt[i] = 0;
            tog_cnt[i]  = 0;
        end
        mis01    = 0;
        prev_sig = '0;
        forever begin
            @(negedge ref_clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", {commit_ack, signal, rise_stb}, e);
            end
            for (int i = 0; i < N; i++) begin
                if (rise_stb[i]) rise_cnt[i]++;
                if (signal[i] != prev_sig[i]) tog_cnt[i]++;
            end
            if (signal[0] != signal[1]) mis01++;
            prev_sig = signal;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge ref_clk);
            #1;
        end
    endtask

    task automatic wr(int ch, logic [31:0] inc, logic en);
        cfg_wr   = 1'b1;
        cfg_addr = 4'(ch);
        cfg_inc  = inc;
        cfg_en   = en;
        tick(1);
        cfg_wr = 1'b0;
    endtask

    task automatic commit(logic sync);
        cfg_commit = 1'b1;
        cfg_sync   = sync;
        tick(1);
        cfg_commit = 1'b0;
        cfg_sync   = 1'b0;
    endtask

    initial begin
        int           snap;
        int           snap2;
        int           c;
        int unsigned  mode;
        logic [31:0]  inc;

        rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_inc = '0;
        cfg_en = 1'b0; cfg_commit = 1'b0; cfg_sync = 1'b0;
        repeat (3) @(posedge ref_clk);
        #2 rst_n = 1'b1;
        tick(1);
        check("reset_state", {commit_ack, signal, rise_stb}, 9'h0);

        // Basic rate: period 8.
        wr(0, 32'h4000_0000, 1'b1);
        commit(1'b0);
        tick(8);
        snap = rise_cnt[0]; snap2 = tog_cnt[0];
        tick(80);
        check("basic_rises", 64'(rise_cnt[0] - snap), 64'd10);
        check("basic_toggles", 64'(tog_cnt[0] - snap2), 64'd20);

        // Shadow isolation, then phase-continuous rate change.
        wr(0, 32'h8000_0000, 1'b1);
        tick(4);
        snap = rise_cnt[0];
        tick(96);
        check("shadow_isolated", 64'(rise_cnt[0] - snap), 64'd12);
        commit(1'b0);
        tick(4);
        snap = rise_cnt[0];
        tick(96);
        check("new_rate", 64'(rise_cnt[0] - snap), 64'd24);

        // Sync alignment.
        wr(0, 32'h1000_0000, 1'b1);
        commit(1'b0);
        tick(5);
        wr(1, 32'h1000_0000, 1'b1);
        commit(1'b0);
        tick(7);
        commit(1'b1);
        snap = mis01; snap2 = rise_cnt[1];
        tick(320);
        check("sync_aligned", 64'(mis01 - snap), 64'd0);
        check("sync_rises", 64'(rise_cnt[1] - snap2), 64'd10);

        // Max rate.
        wr(2, 32'hFFFF_FFFF, 1'b1);
        commit(1'b0);
        tick(2);
        snap = tog_cnt[2];
        tick(1000);
        check_range("max_rate_toggles", tog_cnt[2] - snap, 999, 1001);

        // inc = 0 holds the level.
        wr(3, 32'h8000_0000, 1'b1);
        commit(1'b0);
        tick(3);
        wr(3, 32'h0, 1'b1);
        commit(1'b0);
        tick(2);
        snap = tog_cnt[3];
        tick(20);
        check("zero_inc_hold", 64'(tog_cnt[3] - snap), 64'd0);

        // Out-of-range addresses change nothing.
        wr(4, 32'h0, 1'b0);
        wr(12, 32'h0, 1'b0);
        commit(1'b0);
        tick(4);
        snap = rise_cnt[1];
        tick(64);
        check("bad_addr_ignored", 64'(rise_cnt[1] - snap), 64'd2);

        // Same-cycle write + commit disabling ch2.
        cfg_wr = 1'b1; cfg_addr = 4'd2; cfg_inc = 32'hFFFF_FFFF; cfg_en = 1'b0;
        cfg_commit = 1'b1;
        tick(1);
        cfg_wr = 1'b0; cfg_commit = 1'b0;
        check("bypass_disable", 64'(signal[2]), 64'd0);
        check("bypass_ack", 64'(commit_ack), 64'd1);
        tick(3);

        // Re-enable: first rise in cycle M+5 for k = 4.
        wr(2, 32'h4000_0000, 1'b1);
        commit(1'b0);
        c = 1;
        while (!rise_stb[2] && c < 20) begin
            tick(1);
            c++;
        end
        check("reenable_first_rise", 64'(c), 64'd5);

        // Reset during a high half-period of all channels.
        for (int i = 0; i < N; i++) wr(i, 32'h4000_0000, 1'b1);
        commit(1'b1);
        tick(5);
        check("all_high", 64'(signal), 64'hF);
        #1 rst_n = 1'b0;
        #1;
        check("reset_immediate", {commit_ack, signal, rise_stb}, 9'h0);
        tick(3);
        @(posedge ref_clk);
        #2 rst_n = 1'b1;
        snap = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
        tick(40);
        check("post_reset_quiet",
              64'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3] - snap), 64'd0);
        check("post_reset_low", 64'(signal), 64'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0:       inc = $urandom;
                1:       inc = 32'h1 << $urandom_range(26, 31);
                2:       inc = 32'h0;
                default: inc = 32'hFFFF_FFFF - $urandom_range(0, 15);
            endcase
            cfg_wr     = ($urandom_range(0, 3) == 0);
            cfg_addr   = 4'($urandom_range(0, 5));
            cfg_inc    = inc;
            cfg_en     = ($urandom_range(0, 3) != 0);
            cfg_commit = ($urandom_range(0, 7) == 0);
            cfg_sync   = ($urandom_range(0, 3) == 0);
            tick(1);
        end
        cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_sync = 1'b0;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
